// File: rtl/uart_rx_loader.sv
// Loads a program image from the UART RX byte stream into word memory.
// A 4-byte little-endian header gives the word count N; N little-endian words follow.
module uart_rx_loader #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_ready,
    input  logic [7:0]            rdata,
    input  logic                  ferr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [31:0]           word_count
);

    // state   | meaning
    // IDLE    | waiting for start after reset
    // HEADER  | collecting the 4 word-count bytes, then validating N
    // PAYLOAD | assembling words and writing them from address 0
    // DONE    | image loaded; start re-arms
    // ERROR   | framing error or oversized N; left only by reset
    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DONE,
        ERROR
    } state_t;

    localparam logic [32:0] MAX_N = 33'(1) << ADDR_WIDTH;

    state_t                state;
    logic [1:0]            byte_idx;
    logic                  hdr_full;
    logic [ADDR_WIDTH:0]   words_done;
    logic [ADDR_WIDTH:0]   words_next;
    logic                  last_word;

    assign words_next = words_done + (ADDR_WIDTH+1)'(1);
    assign last_word  = (33'(words_next) == {1'b0, word_count});

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            byte_idx   <= '0;
            hdr_full   <= 1'b0;
            words_done <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= HEADER;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        byte_idx   <= '0;
                        hdr_full   <= 1'b0;
                        word_count <= '0;
                        mem_addr   <= '0;
                        words_done <= '0;
                    end
                end

                HEADER: begin
                    if (ferr) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (hdr_full) begin
                        hdr_full <= 1'b0;
                        if (word_count == 32'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if ({1'b0, word_count} > MAX_N) begin
                            state <= ERROR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state <= PAYLOAD;
                            // a strobe during the decision cycle is the first payload byte
                            if (rx_ready) begin
                                mem_wdata[7:0] <= rdata;
                                byte_idx       <= 2'd1;
                            end
                        end
                    end else if (rx_ready) begin
                        word_count[{byte_idx, 3'b000} +: 8] <= rdata;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            hdr_full <= 1'b1;
                        end
                    end
                end

                PAYLOAD: begin
                    if (ferr) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        if (mem_we) begin
                            mem_addr   <= mem_addr + ADDR_WIDTH'(1);
                            words_done <= words_next;
                            if (last_word) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                        // mem_wdata is already presented to memory, so the next word may start now
                        if (rx_ready && !(mem_we && last_word)) begin
                            mem_wdata[{byte_idx, 3'b000} +: 8] <= rdata;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                mem_we <= 1'b1;
                            end
                        end
                    end
                end

                ERROR: begin
                end

                default: begin
                    state <= ERROR;
                    busy  <= 1'b0;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader, built with ADDR_WIDTH=4 so the
// maximum-count and oversize boundaries are reachable quickly.
module tb_uart_rx_loader;

    localparam int AW = 4;

    logic          clock;
    logic          reset;
    logic          start;
    logic          rx_ready;
    logic [7:0]    rdata;
    logic          ferr;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   word_count;

    int errors = 0;
    int checks = 0;
    int dbl    = 0;
    logic prev_we = 1'b0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    uart_rx_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rx_ready   (rx_ready),
        .rdata      (rdata),
        .ferr       (ferr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            if (prev_we) dbl++;
        end
        prev_we = mem_we;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rdata    = b;
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        if (gap > 0) cyc(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send(w[7:0], gap);
        send(w[15:8], gap);
        send(w[23:16], gap);
        send(w[31:24], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] model_word(input int i);
        return {8'(i), 8'hC3, 8'(i * 3), 8'(8'hF0 ^ i)};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, err, mem_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, mem_we});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'd0 || word_count !== 32'd0) begin
            errors++; $display("FAIL reset_data: addr=%h wdata=%h wc=%h expected zeros", mem_addr, mem_wdata, word_count);
        end
    endtask

    task automatic test_basic();
        wa.delete(); wd.delete();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        send_word(32'd2, 1);
        checks++;
        if (word_count !== 32'd2) begin errors++; $display("FAIL basic_wc: got %h expected 2", word_count); end
        send(8'h78, 1); send(8'h56, 1); send(8'h34, 1); send(8'h12, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 32'h12345678) begin
            errors++; $display("FAIL basic_w0: we=%b addr=%h data=%h expected 1 0 12345678", mem_we, mem_addr, mem_wdata);
        end
        cyc(1);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 4'd1) begin
            errors++; $display("FAIL basic_after_w0: we=%b addr=%h expected 0 1", mem_we, mem_addr);
        end
        send(8'hEF, 1); send(8'hBE, 1); send(8'hAD, 1); send(8'hDE, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_w1: we=%b addr=%h data=%h expected 1 1 deadbeef", mem_we, mem_addr, mem_wdata);
        end
        cyc(2);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || word_count !== 32'd2) begin
            errors++; $display("FAIL basic_done: done=%b busy=%b wc=%h expected 1 0 2", done, busy, word_count);
        end
        checks++;
        if (wa.size() != 2 || dbl != 0) begin
            errors++; $display("FAIL basic_writes: writes=%0d long_pulses=%0d expected 2 0", wa.size(), dbl);
        end
    endtask

    task automatic test_zero();
        wa.delete(); wd.delete();
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_restart: done=%b busy=%b expected 0 1", done, busy);
        end
        send_word(32'd0, 1);
        cyc(2);
        checks++;
        if (done !== 1'b1 || wa.size() != 0 || word_count !== 32'd0) begin
            errors++; $display("FAIL zero_done: done=%b writes=%0d wc=%h expected 1 0 0", done, wa.size(), word_count);
        end
    endtask

    task automatic test_too_big();
        wa.delete(); wd.delete();
        pulse_start();
        send_word(32'd17, 1);
        cyc(2);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wa.size() != 0) begin
            errors++; $display("FAIL big_err: err=%b busy=%b done=%b writes=%0d expected 1 0 0 0", err, busy, done, wa.size());
        end
        pulse_start();
        cyc(2);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL big_sticky: err=%b busy=%b expected 1 0", err, busy);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL big_reset: err=%b expected 0", err); end
    endtask

    task automatic test_ferr();
        wa.delete(); wd.delete();
        pulse_start();
        send_word(32'd1, 1);
        send(8'h11, 1); send(8'h22, 1);
        ferr = 1'b1;
        cyc(1);
        ferr = 1'b0;
        cyc(2);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || wa.size() != 0) begin
            errors++; $display("FAIL ferr_mid: err=%b busy=%b writes=%0d expected 1 0 0", err, busy, wa.size());
        end
        do_reset();
        pulse_start();
        send_word(32'd1, 1);
        send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
        rdata = 8'h44; rx_ready = 1'b1; ferr = 1'b1;
        cyc(1);
        rx_ready = 1'b0; ferr = 1'b0;
        checks++;
        if (err !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL ferr_same: err=%b we=%b expected 1 0", err, mem_we);
        end
        cyc(2);
        checks++;
        if (wa.size() != 0) begin errors++; $display("FAIL ferr_nowrite: writes=%0d expected 0", wa.size()); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        wa.delete(); wd.delete();
        send(8'hAA, 1); send(8'hBB, 1);
        pulse_start();
        send_word(32'd2, 1);
        checks++;
        if (word_count !== 32'd2) begin errors++; $display("FAIL b2b_wc: got %h expected 2", word_count); end
        send_word(32'hCAFEF00D, 0);
        send_word(32'h0BADC0DE, 0);
        cyc(3);
        checks++;
        if (wa.size() != 2) begin
            errors++; $display("FAIL b2b_count: writes=%0d expected 2", wa.size());
        end else if (wa[0] !== 4'd0 || wd[0] !== 32'hCAFEF00D || wa[1] !== 4'd1 || wd[1] !== 32'h0BADC0DE) begin
            errors++; $display("FAIL b2b_data: %h@%h %h@%h expected cafef00d@0 0badc0de@1", wd[0], wa[0], wd[1], wa[1]);
        end
        send_word(32'h55667788, 1);
        cyc(2);
        checks++;
        if (done !== 1'b1 || wa.size() != 2 || word_count !== 32'd2) begin
            errors++; $display("FAIL after_done: done=%b writes=%0d wc=%h expected 1 2 2", done, wa.size(), word_count);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_word(32'd2, 1);
        send_word(32'h01020304, 1);
        send(8'h99, 1);
        wa.delete(); wd.delete();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        checks++;
        if ({busy, done, err, mem_we} !== 4'b0000 || mem_addr !== '0 || mem_wdata !== 32'd0 || word_count !== 32'd0) begin
            errors++; $display("FAIL mid_reset: flags=%b addr=%h wdata=%h wc=%h expected zeros",
                               {busy, done, err, mem_we}, mem_addr, mem_wdata, word_count);
        end
        send_word(32'h77777777, 1);
        cyc(2);
        checks++;
        if (wa.size() != 0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_idle: writes=%0d done=%b expected 0 0", wa.size(), done);
        end
        pulse_start();
        send_word(32'd1, 1);
        send_word(32'hA5A51234, 1);
        cyc(2);
        checks++;
        if (wa.size() != 1) begin
            errors++; $display("FAIL mid_reload_count: writes=%0d expected 1", wa.size());
        end else if (wa[0] !== 4'd0 || wd[0] !== 32'hA5A51234 || done !== 1'b1) begin
            errors++; $display("FAIL mid_reload: %h@%h done=%b expected a5a51234@0 1", wd[0], wa[0], done);
        end
    endtask

    task automatic test_max_count();
        wa.delete(); wd.delete();
        pulse_start();
        send_word(32'd16, 1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL max_accept: err=%b busy=%b expected 0 1", err, busy);
        end
        for (int i = 0; i < 16; i++) send_word(model_word(i), 0);
        cyc(3);
        checks++;
        if (done !== 1'b1 || mem_addr !== 4'd0 || wa.size() != 16 || dbl != 0) begin
            errors++; $display("FAIL max_end: done=%b addr=%h writes=%0d long_pulses=%0d expected 1 0 16 0",
                               done, mem_addr, wa.size(), dbl);
        end
        for (int i = 0; i < 16 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 4'(i) || wd[i] !== model_word(i)) begin
                errors++; $display("FAIL max_word%0d: %h@%h expected %h@%h", i, wd[i], wa[i], model_word(i), 4'(i));
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_ready = 1'b0; rdata = 8'h00; ferr = 1'b0;
        cyc(1);
        test_reset();
        test_basic();
        test_zero();
        test_too_big();
        test_ferr();
        test_back_to_back();
        test_reset_mid();
        test_max_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
